// File: rtl/onehot_channel_sequencer_if.sv
// Channel sequencer bus: enable/request/dwell in, one-hot select and slot
// framing out. The master side is whoever drives requests (the bench, or the
// channel front-end). The slave side is the sequencer itself.
interface onehot_channel_sequencer_if #(
    parameter int NUM_CH      = 4,
    parameter int DWELL_WIDTH = 8
);
    logic                   en;
    logic [NUM_CH-1:0]      req;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [NUM_CH-1:0]      sel;
    logic [1:0]             ch_idx;
    logic                   valid;
    logic                   slot_start;

    modport master (
        output en,
        output req,
        output dwell,
        input  sel,
        input  ch_idx,
        input  valid,
        input  slot_start
    );

    modport slave (
        input  en,
        input  req,
        input  dwell,
        output sel,
        output ch_idx,
        output valid,
        output slot_start
    );
endinterface

// File: rtl/onehot_channel_sequencer.sv
// Round-robin time-slot sequencer for the 4:1 one-hot mux that feeds the
// shared DSP datapath. It grants one requesting channel at a time for a
// programmable dwell and reports the active channel plus a slot-start strobe.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | no slot running, sel = 0; a slot starts at the next edge with
//           | en = 1 and any req bit set
//  ST_GRANT | sel drives the winner; the slot counter counts down to 0, then
//           | the next slot follows back-to-back or the FSM returns to idle
module onehot_channel_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int DWELL_WIDTH = 8
) (
    input logic                       clk,
    input logic                       rst_n,
    onehot_channel_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [NUM_CH-1:0]      SEL_ONE  = NUM_CH'(1);
    localparam logic [DWELL_WIDTH-1:0] CNT_ONE  = DWELL_WIDTH'(1);
    localparam logic [DWELL_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);

    logic [0:0]             state_q;
    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [NUM_CH-1:0]      sel_q;
    logic [IDX_W-1:0]       ch_idx_q;
    logic                   slot_start_q;

    logic                   slot_end;
    logic                   start_slot;
    logic [IDX_W-1:0]       rr_base;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [IDX_W-1:0]       cand;
    logic [DWELL_WIDTH-1:0] cnt_load;

    // Slot framing: the last cycle of a slot is the one where the counter is 0.
    // The pointer update at that edge must already steer the back-to-back
    // winner, so the search base bypasses ptr_q in that cycle.
    always_comb begin
        slot_end   = (state_q == ST_GRANT) && (cnt_q == CNT_ZERO);
        start_slot = bus.en && (|bus.req) && ((state_q == ST_IDLE) || slot_end);
        rr_base    = slot_end ? (ch_idx_q + IDX_ONE) : ptr_q;
        cnt_load   = (bus.dwell == CNT_ZERO) ? CNT_ZERO : (bus.dwell - CNT_ONE);
    end

    // Round-robin winner: first set request bit starting at rr_base, wrapping.
    always_comb begin
        win_idx   = rr_base;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = rr_base + IDX_W'(i);
            if (!win_found && bus.req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // FSM state and the slot down-counter (dwell is sampled only at slot start).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (start_slot) begin
            state_q <= ST_GRANT;
            cnt_q   <= cnt_load;
        end else if (slot_end) begin
            state_q <= ST_IDLE;
        end else if (state_q == ST_GRANT) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Round-robin pointer advances past the channel whose slot just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (slot_end) begin
            ptr_q <= ch_idx_q + IDX_ONE;
        end
    end

    // Registered mux select and channel index; ch_idx holds its value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            ch_idx_q <= '0;
        end else if (start_slot) begin
            sel_q    <= SEL_ONE << win_idx;
            ch_idx_q <= win_idx;
        end else if (slot_end) begin
            sel_q <= '0;
        end
    end

    // Slot-start strobe: high exactly in the first cycle of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_start_q <= 1'b0;
        end else begin
            slot_start_q <= start_slot;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.ch_idx     = ch_idx_q;
    assign bus.valid      = |sel_q;
    assign bus.slot_start = slot_start_q;

    // The mux must never see two selects at once.
    a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_q));
    // While granting, the binary index agrees with the one-hot select.
    a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
        (|sel_q) |-> (sel_q == (SEL_ONE << ch_idx_q)));

endmodule

// File: tb/tb_onehot_channel_sequencer.sv
// Bench for the one-hot channel sequencer: directed scenarios plus a random
// run, all checked against a slot-level reference model.
module tb_onehot_channel_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    onehot_channel_sequencer_if #(.NUM_CH(4), .DWELL_WIDTH(8)) bus();

    onehot_channel_sequencer #(.NUM_CH(4), .DWELL_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a slot is "active" with a number of cycles left.
    bit m_active;
    int m_ch;
    int m_left;
    int m_ptr;
    bit m_ss;

    function automatic void model_reset();
        m_active = 1'b0;
        m_ch     = 0;
        m_left   = 0;
        m_ptr    = 0;
        m_ss     = 1'b0;
    endfunction

    function automatic void model_edge(bit en_v, logic [3:0] req_v, int dw);
        bit ending;
        bit found;
        int c;
        ending = m_active && (m_left == 1);
        if (ending) m_ptr = (m_ch + 1) % 4;
        if (m_active && !ending) begin
            m_left = m_left - 1;
            m_ss   = 1'b0;
        end else if (en_v && (req_v != 4'b0)) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && req_v[c]) begin
                    m_ch  = c;
                    found = 1'b1;
                end
            end
            m_active = 1'b1;
            m_left   = (dw == 0) ? 1 : dw;
            m_ss     = 1'b1;
        end else begin
            m_active = 1'b0;
            m_ss     = 1'b0;
        end
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] s;
        s = m_active ? 4'(1 << m_ch) : 4'b0;
        return {s, 2'(m_ch), m_active, m_ss};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.sel, bus.ch_idx, bus.valid, bus.slot_start};
    endfunction

    // One clock edge: advance the model with the inputs the DUT saw, settle.
    task automatic tick();
        @(posedge clk);
        model_edge(bus.en, bus.req, int'(bus.dwell));
        #1;
    endtask

    task automatic do_reset();
        bus.en    = 1'b0;
        bus.req   = 4'b0;
        bus.dwell = 8'd1;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        do_reset();
        #1;
        n_checks++;
        obs = dut_vec();
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 00", obs);
        end
        bus.en    = 1'b1;
        bus.req   = 4'b0100;
        bus.dwell = 8'd5;
        tick();
        tick();
        n_checks++;
        if (bus.sel !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_pre_ch2: sel %b want 0100", bus.sel);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        obs = dut_vec();
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 00", obs);
        end
        @(negedge clk);
        bus.req   = 4'b0001;
        bus.dwell = 8'd2;
        rst_n     = 1'b1;
        tick();
        n_checks++;
        obs = dut_vec();
        if (obs !== 8'b0001_00_1_1) begin
            n_fail++;
            $display("FAIL reset_regrant_ch0: got %b want 00010011", obs);
        end
    endtask

    task automatic test_single_channel();
        logic [7:0] obs;
        do_reset();
        bus.en    = 1'b1;
        bus.req   = 4'b0001;
        bus.dwell = 8'd3;
        for (int i = 0; i < 12; i++) begin
            tick();
            obs = dut_vec();
            n_checks++;
            if (obs !== {4'b0001, 2'd0, 1'b1, 1'(i % 3 == 0)}) begin
                n_fail++;
                $display("FAIL single_ch cyc%0d: got %b want sel0001 ss=%0d", i, obs, (i % 3 == 0));
            end
            n_checks++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL single_ch_model cyc%0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_sel [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                    4'b0100, 4'b1000, 4'b1000, 4'b0001};
        int         exp_idx [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        do_reset();
        bus.en    = 1'b1;
        bus.req   = 4'b1111;
        bus.dwell = 8'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (bus.sel !== exp_sel[i] || bus.ch_idx !== 2'(exp_idx[i]) ||
                bus.slot_start !== 1'(i % 2 == 0)) begin
                n_fail++;
                $display("FAIL round_robin cyc%0d: sel %b idx %0d ss %b want sel %b idx %0d",
                         i, bus.sel, bus.ch_idx, bus.slot_start, exp_sel[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_skip_idle_channels();
        logic [3:0] exp_sel [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        do_reset();
        bus.en    = 1'b1;
        bus.req   = 4'b0010;
        bus.dwell = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req = 4'b1010;
            n_checks++;
            if (bus.sel !== exp_sel[i] || bus.valid !== 1'b1) begin
                n_fail++;
                $display("FAIL skip_ch cyc%0d: sel %b valid %b want %b", i, bus.sel, bus.valid, exp_sel[i]);
            end
        end
    endtask

    task automatic test_dwell_zero();
        logic [7:0] obs;
        do_reset();
        bus.en    = 1'b1;
        bus.req   = 4'b0011;
        bus.dwell = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = dut_vec();
            n_checks++;
            if (obs !== {((i % 2 == 0) ? 4'b0001 : 4'b0010), 2'(i % 2), 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL dwell_zero cyc%0d: got %b", i, obs);
            end
        end
    endtask

    task automatic test_en_drop_mid_slot();
        logic [7:0] obs;
        do_reset();
        bus.en    = 1'b1;
        bus.req   = 4'b0001;
        bus.dwell = 8'd4;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) begin
                bus.en  = 1'b0;
                bus.req = 4'b0000;
            end
            obs = dut_vec();
            n_checks++;
            if (obs !== ((i < 4) ? {4'b0001, 2'd0, 1'b1, 1'(i == 0)} : 8'b0000_00_0_0)) begin
                n_fail++;
                $display("FAIL en_drop cyc%0d: got %b", i, obs);
            end
            n_checks++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL en_drop_model cyc%0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] obs;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.en    = ($urandom_range(0, 7) != 0);
            bus.req   = 4'($urandom_range(0, 15));
            bus.dwell = 8'($urandom_range(0, 4));
            tick();
            obs = dut_vec();
            n_checks++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs, model_vec());
            end
        end
    endtask

    initial begin
        bus.en    = 1'b0;
        bus.req   = 4'b0;
        bus.dwell = 8'd1;
        model_reset();
        test_reset();
        test_single_channel();
        test_round_robin();
        test_skip_idle_channels();
        test_dwell_zero();
        test_en_drop_mid_slot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
